// File: rtl/bram_port_arbiter.sv
// Single-port BRAM arbiter: instruction fetch, data read bursts and data write bursts
// share one synchronous BRAM port, with fixed-priority or round-robin selection.
module bram_port_arbiter #(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int BURST     = 4,
    parameter int INST_BASE = 0,
    parameter int RD_BASE   = 28,
    parameter int WR_BASE   = 140,
    parameter int ARB_RR    = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inst_req,
    input  logic [AW-1:0] inst_idx,
    output logic          inst_gnt,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_idx,
    output logic          rd_gnt,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_idx,
    output logic          wr_gnt,
    input  logic [DW-1:0] wr_data,
    output logic          wr_beat_rdy,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_src,
    output logic          rd_last,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int LOG2B = $clog2(BURST);
    localparam int BW    = (LOG2B > 0) ? LOG2B : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);
    localparam logic [AW-1:0] INST_BASE_A = AW'(INST_BASE);
    localparam logic [AW-1:0] RD_BASE_A   = AW'(RD_BASE);
    localparam logic [AW-1:0] WR_BASE_A   = AW'(WR_BASE);

    // Source ids double as round-robin pointer values: 0 = inst, 1 = rd, 2 = wr
    localparam logic [1:0] SRC_INST = 2'd0;
    localparam logic [1:0] SRC_RD   = 2'd1;
    localparam logic [1:0] SRC_WR   = 2'd2;

    typedef enum logic [1:0] {IDLE, INST, RD, WR} state_t;

    state_t        state_reg;
    logic [BW-1:0] beat_reg;
    logic [1:0]    ptr_reg;
    logic [AW-1:0] addr_reg;
    logic          we_reg;
    logic          inst_gnt_reg;
    logic          rd_gnt_reg;
    logic          wr_gnt_reg;
    logic          rd_valid_reg;
    logic          rd_src_reg;
    logic          rd_last_reg;

    logic [2:0]    req_vec;
    logic          any_req;
    logic [1:0]    win_next;
    logic [1:0]    p0_next;
    logic [1:0]    p1_next;
    logic [1:0]    p2_next;
    logic [AW-1:0] win_addr_next;

    function automatic logic [1:0] src_succ(input logic [1:0] s);
        return (s == SRC_WR) ? SRC_INST : s + 2'd1;
    endfunction

    assign req_vec = {wr_req, rd_req, inst_req};
    assign any_req = |req_vec;

    always_comb begin
        win_next = SRC_INST;
        p0_next  = ptr_reg;
        p1_next  = src_succ(ptr_reg);
        p2_next  = src_succ(p1_next);
        if (ARB_RR != 0) begin
            // Lowest priority checked first so the highest-priority requester overwrites it
            if (req_vec[p2_next]) win_next = p2_next;
            if (req_vec[p1_next]) win_next = p1_next;
            if (req_vec[p0_next]) win_next = p0_next;
        end else begin
            if (wr_req)   win_next = SRC_WR;
            if (rd_req)   win_next = SRC_RD;
            if (inst_req) win_next = SRC_INST;
        end
    end

    always_comb begin
        win_addr_next = INST_BASE_A + inst_idx;
        case (win_next)
            SRC_RD:  win_addr_next = RD_BASE_A + (rd_idx << LOG2B);
            SRC_WR:  win_addr_next = WR_BASE_A + (wr_idx << LOG2B);
            default: win_addr_next = INST_BASE_A + inst_idx;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            beat_reg     <= '0;
            ptr_reg      <= SRC_INST;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            inst_gnt_reg <= 1'b0;
            rd_gnt_reg   <= 1'b0;
            wr_gnt_reg   <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_src_reg   <= 1'b0;
            rd_last_reg  <= 1'b0;
        end else begin
            inst_gnt_reg <= 1'b0;
            rd_gnt_reg   <= 1'b0;
            wr_gnt_reg   <= 1'b0;
            // Read return trails each INST/RD address cycle by the BRAM latency
            rd_valid_reg <= (state_reg == INST) || (state_reg == RD);
            rd_src_reg   <= (state_reg == RD);
            rd_last_reg  <= (state_reg == INST) || ((state_reg == RD) && (beat_reg == LAST_BEAT));
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        addr_reg <= win_addr_next;
                        beat_reg <= '0;
                        ptr_reg  <= src_succ(win_next);
                        we_reg   <= (win_next == SRC_WR);
                        case (win_next)
                            SRC_RD: begin
                                state_reg  <= RD;
                                rd_gnt_reg <= 1'b1;
                            end
                            SRC_WR: begin
                                state_reg  <= WR;
                                wr_gnt_reg <= 1'b1;
                            end
                            default: begin
                                state_reg    <= INST;
                                inst_gnt_reg <= 1'b1;
                            end
                        endcase
                    end
                end
                INST: begin
                    state_reg <= IDLE;
                    addr_reg  <= '0;
                end
                RD, WR: begin
                    if (beat_reg == LAST_BEAT) begin
                        state_reg <= IDLE;
                        addr_reg  <= '0;
                        we_reg    <= 1'b0;
                        beat_reg  <= '0;
                    end else begin
                        beat_reg <= beat_reg + 1'b1;
                        addr_reg <= addr_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    addr_reg  <= '0;
                    we_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign inst_gnt    = inst_gnt_reg;
    assign rd_gnt      = rd_gnt_reg;
    assign wr_gnt      = wr_gnt_reg;
    assign busy        = (state_reg != IDLE);
    assign mem_addr    = addr_reg;
    assign mem_we      = we_reg;
    // Write beats pass straight through so the processor's current beat lands this cycle
    assign mem_wdata   = we_reg ? wr_data : '0;
    assign wr_beat_rdy = we_reg;
    assign rd_valid    = rd_valid_reg;
    assign rd_data     = rd_valid_reg ? mem_rdata : '0;
    assign rd_src      = rd_src_reg;
    assign rd_last     = rd_last_reg;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized bench for bram_port_arbiter: a BRAM model plus a shadow memory and
// address/timing expectations derived from the window and burst rules.
module tb_bram_port_arbiter;
    localparam int DW = 8, AW = 8, BURST = 4;
    localparam int INST_BASE = 0, RD_BASE = 28, WR_BASE = 140;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          inst_req, rd_req, wr_req;
    logic [AW-1:0] inst_idx, rd_idx, wr_idx;
    logic          inst_gnt, rd_gnt, wr_gnt;
    logic [DW-1:0] wr_data;
    logic          wr_beat_rdy, rd_valid, rd_src, rd_last, busy, mem_we;
    logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    // Second instance in round-robin mode
    logic          r_inst_req, r_rd_req, r_wr_req;
    logic          r_inst_gnt, r_rd_gnt, r_wr_gnt;
    logic          r_wr_beat_rdy, r_rd_valid, r_rd_src, r_rd_last, r_busy, r_mem_we;
    logic [DW-1:0] r_rd_data, r_mem_wdata;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_zero_d = '0;
    logic [AW-1:0] r_zero_a = '0;

    logic [DW-1:0] bram [256];
    logic [DW-1:0] ref_mem [256];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.DW(DW), .AW(AW), .BURST(BURST), .INST_BASE(INST_BASE),
                        .RD_BASE(RD_BASE), .WR_BASE(WR_BASE), .ARB_RR(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_req(inst_req), .inst_idx(inst_idx), .inst_gnt(inst_gnt),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_gnt(rd_gnt),
        .wr_req(wr_req), .wr_idx(wr_idx), .wr_gnt(wr_gnt),
        .wr_data(wr_data), .wr_beat_rdy(wr_beat_rdy),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_src(rd_src), .rd_last(rd_last),
        .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    bram_port_arbiter #(.DW(DW), .AW(AW), .BURST(BURST), .INST_BASE(INST_BASE),
                        .RD_BASE(RD_BASE), .WR_BASE(WR_BASE), .ARB_RR(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .inst_req(r_inst_req), .inst_idx(r_zero_a), .inst_gnt(r_inst_gnt),
        .rd_req(r_rd_req), .rd_idx(r_zero_a), .rd_gnt(r_rd_gnt),
        .wr_req(r_wr_req), .wr_idx(r_zero_a), .wr_gnt(r_wr_gnt),
        .wr_data(r_zero_d), .wr_beat_rdy(r_wr_beat_rdy),
        .rd_valid(r_rd_valid), .rd_data(r_rd_data), .rd_src(r_rd_src), .rd_last(r_rd_last),
        .busy(r_busy), .mem_addr(r_mem_addr), .mem_we(r_mem_we), .mem_wdata(r_mem_wdata),
        .mem_rdata(r_zero_d)
    );

    // Synchronous BRAM, one-cycle read latency
    always @(posedge clk) begin
        if (mem_we) bram[mem_addr] <= mem_wdata;
        mem_rdata <= bram[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] burst_addr(input int base, input int idx, input int b);
        return AW'((base + idx * BURST + b) % 256);
    endfunction

    task automatic do_inst(input int idx);
        int n;
        logic [AW-1:0] a;
        a = AW'((INST_BASE + idx) % 256);
        inst_req = 1'b1;
        inst_idx = AW'(idx);
        n = 0;
        do begin @(negedge clk); n++; end while (!inst_gnt && n < 20);
        inst_req = 1'b0;
        if (!inst_gnt) begin check_eq("inst_gnt_timeout", 0, 1); return; end
        check_eq("inst_addr", mem_addr, a);
        check_eq("inst_we", mem_we, 0);
        check_eq("inst_busy", busy, 1);
        @(negedge clk);
        check_eq("inst_valid", rd_valid, 1);
        check_eq("inst_src", rd_src, 0);
        check_eq("inst_last", rd_last, 1);
        check_eq("inst_data", rd_data, ref_mem[a]);
        check_eq("inst_gnt_pulse", inst_gnt, 0);
        check_eq("inst_idle", busy, 0);
        $display("inst idx=%0d addr=%0d data=%0h", idx, a, rd_data);
    endtask

    task automatic do_rd(input int idx);
        int n;
        rd_req = 1'b1;
        rd_idx = AW'(idx);
        n = 0;
        do begin @(negedge clk); n++; end while (!rd_gnt && n < 20);
        rd_req = 1'b0;
        if (!rd_gnt) begin check_eq("rd_gnt_timeout", 0, 1); return; end
        for (int b = 0; b <= BURST; b++) begin
            if (b > 0) @(negedge clk);
            if (b < BURST) begin
                check_eq("rd_addr", mem_addr, burst_addr(RD_BASE, idx, b));
                check_eq("rd_we", mem_we, 0);
                check_eq("rd_busy", busy, 1);
            end
            if (b == 0) check_eq("rd_valid_early", rd_valid, 0);
            if (b == 1) check_eq("rd_gnt_pulse", rd_gnt, 0);
            if (b > 0) begin
                check_eq("rd_valid", rd_valid, 1);
                check_eq("rd_src", rd_src, 1);
                check_eq("rd_last", rd_last, (b == BURST) ? 1 : 0);
                check_eq("rd_data", rd_data, ref_mem[burst_addr(RD_BASE, idx, b - 1)]);
            end
        end
        check_eq("rd_idle", busy, 0);
        $display("rd idx=%0d base_addr=%0d", idx, burst_addr(RD_BASE, idx, 0));
    endtask

    task automatic do_wr(input int idx, input int abort_at);
        int n;
        logic [DW-1:0] d [BURST];
        logic [AW-1:0] a;
        for (int i = 0; i < BURST; i++) d[i] = DW'($urandom);
        wr_req  = 1'b1;
        wr_idx  = AW'(idx);
        wr_data = d[0];
        n = 0;
        do begin @(negedge clk); n++; end while (!wr_gnt && n < 20);
        wr_req = 1'b0;
        if (!wr_gnt) begin check_eq("wr_gnt_timeout", 0, 1); return; end
        for (int b = 0; b < BURST; b++) begin
            if (b > 0) @(negedge clk);
            a = burst_addr(WR_BASE, idx, b);
            check_eq("wr_we", mem_we, 1);
            check_eq("wr_addr", mem_addr, a);
            check_eq("wr_wdata", mem_wdata, d[b]);
            check_eq("wr_rdy", wr_beat_rdy, 1);
            check_eq("wr_busy", busy, 1);
            if (b == 1) check_eq("wr_gnt_pulse", wr_gnt, 0);
            if (b == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("abort_we", mem_we, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_rdy", wr_beat_rdy, 0);
                check_eq("abort_addr", mem_addr, 0);
                $display("wr idx=%0d aborted at beat %0d", idx, b);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            ref_mem[a] = d[b];
            if (b < BURST - 1) wr_data = d[b + 1];
        end
        @(negedge clk);
        check_eq("wr_end_we", mem_we, 0);
        check_eq("wr_end_rdy", wr_beat_rdy, 0);
        check_eq("wr_end_wdata", mem_wdata, 0);
        check_eq("wr_idle", busy, 0);
        $display("wr idx=%0d base_addr=%0d", idx, burst_addr(WR_BASE, idx, 0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g_src[$];
        int g_cyc[$];
        inst_req = 0; rd_req = 0; wr_req = 0;
        inst_idx = '0; rd_idx = '0; wr_idx = '0; wr_data = '0;
        r_inst_req = 0; r_rd_req = 0; r_wr_req = 0;
        for (int i = 0; i < 256; i++) begin
            bram[i]    = DW'(i * 7 + 3);
            ref_mem[i] = DW'(i * 7 + 3);
        end
        repeat (3) @(negedge clk);
        check_eq("rst_gnts", {inst_gnt, rd_gnt, wr_gnt}, 0);
        check_eq("rst_valid", rd_valid, 0);
        check_eq("rst_rdata", rd_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_we", {mem_we, wr_beat_rdy}, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_inst(5);
        do_rd(2);
        do_wr(3, -1);
        do_rd(3);
        do_rd(63);

        // All three requesters at once, fixed priority
        inst_req = 1; rd_req = 1; wr_req = 1;
        inst_idx = 8'd9; rd_idx = 8'd7; wr_idx = 8'd10; wr_data = 8'h77;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (inst_gnt) begin g_src.push_back(0); g_cyc.push_back(cyc); inst_req = 0; end
            if (rd_gnt)   begin g_src.push_back(1); g_cyc.push_back(cyc); rd_req = 0; end
            if (wr_gnt)   begin g_src.push_back(2); g_cyc.push_back(cyc); wr_req = 0; end
        end
        check_eq("prio_count", g_src.size(), 3);
        if (g_src.size() == 3) begin
            check_eq("prio_first", g_src[0], 0);
            check_eq("prio_second", g_src[1], 1);
            check_eq("prio_third", g_src[2], 2);
            check_eq("prio_gap1", g_cyc[1] - g_cyc[0], 2);
            check_eq("prio_gap2", g_cyc[2] - g_cyc[1], BURST + 1);
        end
        for (int b = 0; b < BURST; b++) ref_mem[burst_addr(WR_BASE, 10, b)] = 8'h77;
        $display("prio grants=%0d", g_src.size());

        // Round-robin: inst and wr held continuously must alternate
        g_src.delete();
        r_inst_req = 1; r_wr_req = 1;
        for (int cyc = 0; cyc < 60 && g_src.size() < 6; cyc++) begin
            @(negedge clk);
            if (r_inst_gnt) g_src.push_back(0);
            if (r_rd_gnt)   g_src.push_back(1);
            if (r_wr_gnt)   g_src.push_back(2);
        end
        r_inst_req = 0; r_wr_req = 0;
        check_eq("rr_count", g_src.size(), 6);
        for (int i = 0; i < g_src.size(); i++)
            check_eq("rr_order", g_src[i], (i % 2 == 0) ? 0 : 2);
        $display("rr grants=%0d", g_src.size());
        @(negedge clk);

        do_wr(3, 2);
        do_rd(3);
        do_inst(5);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0:       do_inst(int'($urandom_range(0, 255)));
                1:       do_rd(int'($urandom_range(0, 255)));
                default: do_wr(int'($urandom_range(0, 255)), -1);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
